// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush-to-bubble and valid tracking.
// Defining ID_EX_BUBBLE_CNT_EN adds a saturating 16-bit bubble counter on bubble_cnt_o.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              RegDst_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic [2:0]        ALUOp_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  output logic              RegDst_o,
  output logic              ALUSrc_o,
  output logic              RegWrite_o,
  output logic [2:0]        ALUOp_o,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [ADDR_W-1:0] RSaddr_o,
  output logic [ADDR_W-1:0] RTaddr_o,
  output logic [ADDR_W-1:0] RDaddr_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [15:0]       bubble_cnt_o,
`endif
  output logic              valid_o
);

  // Stage contents: reset and flush both load an all-zero bubble; stall holds.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      RegDst_o   <= 1'b0;
      ALUSrc_o   <= 1'b0;
      RegWrite_o <= 1'b0;
      ALUOp_o    <= 3'b000;
      RSdata_o   <= {DATA_W{1'b0}};
      RTdata_o   <= {DATA_W{1'b0}};
      Imm_o      <= {DATA_W{1'b0}};
      RSaddr_o   <= {ADDR_W{1'b0}};
      RTaddr_o   <= {ADDR_W{1'b0}};
      RDaddr_o   <= {ADDR_W{1'b0}};
      valid_o    <= 1'b0;
    end else if (stall_i) begin
      RegDst_o   <= RegDst_o;
      ALUSrc_o   <= ALUSrc_o;
      RegWrite_o <= RegWrite_o;
      ALUOp_o    <= ALUOp_o;
      RSdata_o   <= RSdata_o;
      RTdata_o   <= RTdata_o;
      Imm_o      <= Imm_o;
      RSaddr_o   <= RSaddr_o;
      RTaddr_o   <= RTaddr_o;
      RDaddr_o   <= RDaddr_o;
      valid_o    <= valid_o;
    end else begin
      RegDst_o   <= RegDst_i;
      ALUSrc_o   <= ALUSrc_i;
      RegWrite_o <= RegWrite_i;
      ALUOp_o    <= ALUOp_i;
      RSdata_o   <= RSdata_i;
      RTdata_o   <= RTdata_i;
      Imm_o      <= Imm_i;
      RSaddr_o   <= RSaddr_i;
      RTaddr_o   <= RTaddr_i;
      RDaddr_o   <= RDaddr_i;
      valid_o    <= 1'b1;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  // Bubble counter: one count per flush edge, sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= 16'h0000;
    end else if (flush_i && (bubble_cnt_o != 16'hFFFF)) begin
      bubble_cnt_o <= bubble_cnt_o + 16'd1;
    end else begin
      bubble_cnt_o <= bubble_cnt_o;
    end
  end
`endif

endmodule
